level_queue: RTL

Parametrised first-word-fall-through FIFO that succeeds the game's original queue. It adds arbitrary (non-power-of-two) depth, a live fill level, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a synchronous clear. It sits between event producers (input decode, bomb/explosion timers) and consumers (game-state update, sprite/draw scheduling) wherever elements must be buffered in order.

---
 rtl/level_queue_if.sv | 27 ++
 rtl/level_queue.sv | 57 +++++
 2 files changed

// File: rtl/level_queue_if.sv
// level_queue_if: push/pop/status bundle between a queue and its producer/consumer.
interface level_queue_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH + 1);
  logic clear;
  logic we;
  logic next;
  logic [DATA_WIDTH-1:0] in;
  logic [DATA_WIDTH-1:0] out;
  logic empty;
  logic full;
  logic [LW-1:0] level;
  logic almost_empty;
  logic almost_full;
  logic overflow;
  logic underflow;
  modport master (
    output clear, we, next, in,
    input out, empty, full, level, almost_empty, almost_full, overflow, underflow
  );
  modport slave (
    input clear, we, next, in,
    output out, empty, full, level, almost_empty, almost_full, overflow, underflow
  );
endinterface

// File: rtl/level_queue.sv
// level_queue: FWFT FIFO of arbitrary depth with fill level, thresholds and sticky error flags.
module level_queue #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AFULL_LEVEL = DEPTH - 1,
  parameter int AEMPTY_LEVEL = 1
) (
  input logic clk,
  input logic rst,
  level_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  logic empty, full, pop_ok, push_ok;
  always_comb begin
    empty = level_q == '0;
    full = level_q == LW'(DEPTH);
    pop_ok = q.next && !empty;
    push_ok = q.we && (!full || pop_ok);
    // pointers wrap explicitly so DEPTH need not be a power of two
    wptr_d = q.clear ? '0 : push_ok ? (wptr_q == PW'(DEPTH - 1) ? '0 : wptr_q + 1'b1) : wptr_q;
    rptr_d = q.clear ? '0 : pop_ok ? (rptr_q == PW'(DEPTH - 1) ? '0 : rptr_q + 1'b1) : rptr_q;
    level_d = q.clear ? '0 : level_q + LW'(push_ok) - LW'(pop_ok);
    overflow_d = !q.clear && (overflow_q || (q.we && !push_ok));
    underflow_d = !q.clear && (underflow_q || (q.next && empty));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      level_q <= '0;
      overflow_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      level_q <= level_d;
      overflow_q <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok && !q.clear) mem[wptr_q] <= q.in;
  end
  assign q.out = empty ? '0 : mem[rptr_q];
  assign q.empty = empty;
  assign q.full = full;
  assign q.level = level_q;
  assign q.almost_empty = level_q <= LW'(AEMPTY_LEVEL);
  assign q.almost_full = level_q >= LW'(AFULL_LEVEL);
  assign q.overflow = overflow_q;
  assign q.underflow = underflow_q;
endmodule
